// File: rtl/jam_search.sv
// jam_search: exhaustive job-assignment search.
// Walks every permutation of N_JOBS jobs over N_JOBS workers in lexicographic
// order. It fetches each (worker, job) cost over a valid/ready-style request
// and keeps three results: the optimum total, how many permutations reach it,
// and the first permutation that reaches it.
module jam_search #(
  parameter int unsigned N_JOBS = 8,
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned COST_W = 7,
  parameter int unsigned SUM_W  = 10,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      START,
  input  logic                      MODE,
  output logic                      REQ,
  output logic [IDX_W-1:0]          W,
  output logic [IDX_W-1:0]          J,
  input  logic                      COST_VLD,
  input  logic [COST_W-1:0]         Cost,
  output logic                      Busy,
  output logic                      Valid,
  output logic [SUM_W-1:0]          MinCost,
  output logic [CNT_W-1:0]          MatchCount,
  output logic [N_JOBS*IDX_W-1:0]   BestPerm
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    UPDATE,
    DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [IDX_W-1:0]   perm     [N_JOBS];
  logic [IDX_W-1:0]   perm_nxt [N_JOBS];
  logic [IDX_W-1:0]   tmp      [N_JOBS];
  logic [IDX_W-1:0]   k;
  logic [SUM_W-1:0]   acc;
  logic               mode_q;
  logic               first_q;

  logic               k_last;
  logic               is_last;
  logic               found;
  logic               better;
  logic [IDX_W-1:0]   cur_job;
  logic [IDX_W-1:0]   pivot_val;
  logic [IDX_W-1:0]   swap_val;
  int unsigned        piv;
  int unsigned        sw;

  assign k_last = (k == IDX_W'(N_JOBS - 1));
  assign is_last = !found;
  assign better = mode_q ? (acc > MinCost) : (acc < MinCost);
  assign W = k;
  assign J = cur_job;

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    REQ       = 1'b0;
    Busy      = 1'b0;
    Valid     = 1'b0;
    case (state)
      IDLE: begin
        if (START) state_nxt = FETCH;
      end
      FETCH: begin
        REQ  = 1'b1;
        Busy = 1'b1;
        if (COST_VLD && k_last) state_nxt = UPDATE;
      end
      UPDATE: begin
        Busy      = 1'b1;
        state_nxt = is_last ? DONE : FETCH;
      end
      DONE: begin
        Valid = 1'b1;
        if (START) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Job currently assigned to worker k.
  always_comb begin
    cur_job = '0;
    for (int unsigned i = 0; i < N_JOBS; i++) begin
      if (k == IDX_W'(i)) cur_job = perm[i];
    end
  end

  // Next lexicographic permutation. All indexing is done by comparing
  // constant loop positions against the pivot/swap positions, so the whole
  // step (find pivot, swap, reverse suffix) stays one combinational cycle.
  always_comb begin
    found     = 1'b0;
    piv       = 0;
    sw        = 0;
    pivot_val = '0;
    swap_val  = '0;
    for (int unsigned i = 0; i < N_JOBS - 1; i++) begin
      if (perm[i] < perm[i+1]) begin
        found = 1'b1;
        piv   = i;
      end
    end
    for (int unsigned i = 0; i < N_JOBS; i++) begin
      if (i == piv) pivot_val = perm[i];
    end
    for (int unsigned i = 0; i < N_JOBS; i++) begin
      if ((i > piv) && (perm[i] > pivot_val)) sw = i;
    end
    for (int unsigned i = 0; i < N_JOBS; i++) begin
      if (i == sw) swap_val = perm[i];
    end
    for (int unsigned i = 0; i < N_JOBS; i++) begin
      if (i == piv) begin
        tmp[i] = swap_val;
      end else if (i == sw) begin
        tmp[i] = pivot_val;
      end else begin
        tmp[i] = perm[i];
      end
    end
    for (int unsigned i = 0; i < N_JOBS; i++) begin
      perm_nxt[i] = tmp[i];
      if (i > piv) begin
        for (int unsigned s = 0; s < N_JOBS; s++) begin
          if (s == N_JOBS + piv - i) perm_nxt[i] = tmp[s];
        end
      end
    end
  end

  // Datapath: permutation, cost accumulation and result registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < N_JOBS; i++) perm[i] <= IDX_W'(i);
      k          <= '0;
      acc        <= '0;
      mode_q     <= 1'b0;
      first_q    <= 1'b0;
      MinCost    <= '0;
      MatchCount <= '0;
      BestPerm   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (START) begin
            mode_q     <= MODE;
            for (int unsigned i = 0; i < N_JOBS; i++) perm[i] <= IDX_W'(i);
            acc        <= '0;
            k          <= '0;
            MatchCount <= '0;
            first_q    <= 1'b1;
          end
        end
        FETCH: begin
          if (COST_VLD) begin
            acc <= acc + SUM_W'(Cost);
            if (!k_last) k <= k + 1'b1;
          end
        end
        UPDATE: begin
          first_q <= 1'b0;
          if (first_q || better) begin
            MinCost    <= acc;
            MatchCount <= CNT_W'(1);
            for (int unsigned i = 0; i < N_JOBS; i++) begin
              BestPerm[i*IDX_W +: IDX_W] <= perm[i];
            end
          end else if ((acc == MinCost) && (MatchCount != '1)) begin
            MatchCount <= MatchCount + 1'b1;
          end
          if (!is_last) begin
            for (int unsigned i = 0; i < N_JOBS; i++) perm[i] <= perm_nxt[i];
            acc <= '0;
            k   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jam_search.sv
// Bench for jam_search: three instances (N_JOBS = 2, 3, 4) share one cost
// matrix and one randomised responder; only the active instance is served.
module tb_jam_search;

  localparam int LIMIT = 5000;

  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  logic start = 1'b0;
  logic MODE = 1'b0;

  int   active = 4;
  int   maxd = 0;
  int   wait_left = 0;
  logic rdy = 1'b0;
  logic noise = 1'b0;
  logic pend = 1'b0;
  int   pend_code = 0;
  logic prev_hold = 1'b0;
  logic [2:0] hold_w = '0;
  logic [2:0] hold_j = '0;

  logic [6:0] cm [8][8];
  int checks = 0;
  int errors = 0;
  int stab_err = 0;
  int range_err = 0;
  int acc_q[$];
  int exp_q[$];

  always #5 CLK = ~CLK;

  logic start2, start3, start4;
  assign start2 = start && (active == 2);
  assign start3 = start && (active == 3);
  assign start4 = start && (active == 4);

  logic req2, busy2, valid2, vld2;
  logic [2:0] w2, j2;
  logic [6:0] cost2;
  logic [9:0] min2;
  logic [15:0] cnt2;
  logic [5:0] perm2;

  logic req3, busy3, valid3, vld3;
  logic [2:0] w3, j3;
  logic [6:0] cost3;
  logic [9:0] min3;
  logic [1:0] cnt3;
  logic [8:0] perm3;

  logic req4, busy4, valid4, vld4;
  logic [2:0] w4, j4;
  logic [6:0] cost4;
  logic [9:0] min4;
  logic [15:0] cnt4;
  logic [11:0] perm4;

  assign cost2 = cm[w2][j2];
  assign cost3 = cm[w3][j3];
  assign cost4 = cm[w4][j4];
  assign vld2 = (active == 2) && (req2 ? rdy : noise);
  assign vld3 = (active == 3) && (req3 ? rdy : noise);
  assign vld4 = (active == 4) && (req4 ? rdy : noise);

  jam_search #(.N_JOBS(2), .IDX_W(3), .COST_W(7), .SUM_W(10), .CNT_W(16)) u2 (
    .CLK(CLK), .RST_N(RST_N), .START(start2), .MODE(MODE), .REQ(req2), .W(w2), .J(j2),
    .COST_VLD(vld2), .Cost(cost2), .Busy(busy2), .Valid(valid2), .MinCost(min2),
    .MatchCount(cnt2), .BestPerm(perm2));

  // Narrow match counter so saturation is reachable (3! = 6 > 3).
  jam_search #(.N_JOBS(3), .IDX_W(3), .COST_W(7), .SUM_W(10), .CNT_W(2)) u3 (
    .CLK(CLK), .RST_N(RST_N), .START(start3), .MODE(MODE), .REQ(req3), .W(w3), .J(j3),
    .COST_VLD(vld3), .Cost(cost3), .Busy(busy3), .Valid(valid3), .MinCost(min3),
    .MatchCount(cnt3), .BestPerm(perm3));

  jam_search #(.N_JOBS(4), .IDX_W(3), .COST_W(7), .SUM_W(10), .CNT_W(16)) u4 (
    .CLK(CLK), .RST_N(RST_N), .START(start4), .MODE(MODE), .REQ(req4), .W(w4), .J(j4),
    .COST_VLD(vld4), .Cost(cost4), .Busy(busy4), .Valid(valid4), .MinCost(min4),
    .MatchCount(cnt4), .BestPerm(perm4));

  logic sel_req, sel_busy, sel_valid;
  logic [2:0] sel_w, sel_j;
  logic [9:0] sel_min;
  logic [15:0] sel_cnt;
  logic [23:0] sel_perm;

  always_comb begin
    case (active)
      2: begin
        sel_req = req2; sel_w = w2; sel_j = j2; sel_busy = busy2; sel_valid = valid2;
        sel_min = min2; sel_cnt = cnt2; sel_perm = 24'(perm2);
      end
      3: begin
        sel_req = req3; sel_w = w3; sel_j = j3; sel_busy = busy3; sel_valid = valid3;
        sel_min = min3; sel_cnt = 16'(cnt3); sel_perm = 24'(perm3);
      end
      default: begin
        sel_req = req4; sel_w = w4; sel_j = j4; sel_busy = busy4; sel_valid = valid4;
        sel_min = min4; sel_cnt = cnt4; sel_perm = 24'(perm4);
      end
    endcase
  end

  // Responder and request monitor, evaluated mid-cycle.
  always @(negedge CLK) begin
    if (prev_hold && sel_req && (sel_w != hold_w || sel_j != hold_j)) stab_err++;
    if (sel_req && (int'(sel_w) >= active || int'(sel_j) >= active)) range_err++;
    if (!sel_req) begin
      rdy = 1'b0;
      wait_left = $urandom_range(maxd, 0);
    end else if (wait_left == 0) begin
      rdy = 1'b1;
    end else begin
      rdy = 1'b0;
      wait_left--;
    end
    noise = 1'($urandom);
    pend = sel_req && rdy;
    pend_code = int'(sel_w) * 8 + int'(sel_j);
    prev_hold = sel_req && !rdy;
    hold_w = sel_w;
    hold_j = sel_j;
  end

  // Record accepted requests and draw the delay for the next one.
  always @(posedge CLK) begin
    if (pend) begin
      acc_q.push_back(pend_code);
      wait_left = $urandom_range(maxd, 0);
      pend = 1'b0;
    end
  end

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t active=%0d)", name, got, want, $time, active);
    end
  endtask

  function automatic int pack(input int n, input int a, input int b, input int c, input int d);
    int r;
    r = a | (b << 3);
    if (n > 2) r = r | (c << 6);
    if (n > 3) r = r | (d << 9);
    return r;
  endfunction

  task automatic set_pat(input int pat, input int hi);
    for (int w = 0; w < 8; w++) begin
      for (int j = 0; j < 8; j++) begin
        case (pat)
          0: cm[w][j] = 7'd1;
          1: cm[w][j] = 7'(w * j);
          2: cm[w][j] = (w == j) ? 7'd3 : 7'd1;
          3: cm[w][j] = 7'($urandom_range(hi, 0));
          4: cm[w][j] = 7'd5;
          default: cm[w][j] = (w == j) ? 7'd0 : 7'd10;
        endcase
      end
    end
  endtask

  // Brute force over all n^n index tuples; tuples with distinct entries come
  // out in lexicographic permutation order (worker 0 is the most significant digit).
  task automatic model(input int n, input bit mode, input int cmax,
                       output int emin, output int ecnt, output int eperm);
    int total, rem, mask, sum, pk;
    int d[4];
    bit first, ok;
    exp_q.delete();
    emin = 0; ecnt = 0; eperm = 0; first = 1'b1;
    total = 1;
    for (int i = 0; i < n; i++) total = total * n;
    for (int code = 0; code < total; code++) begin
      rem = code; mask = 0; ok = 1'b1; sum = 0; pk = 0;
      for (int w = n - 1; w >= 0; w--) begin
        d[w] = rem % n;
        rem = rem / n;
      end
      for (int w = 0; w < n; w++) begin
        if (mask[d[w]]) ok = 1'b0;
        mask = mask | (1 << d[w]);
      end
      if (ok) begin
        for (int w = 0; w < n; w++) begin
          sum = sum + int'(cm[w][d[w]]);
          pk = pk | (d[w] << (3 * w));
          exp_q.push_back(w * 8 + d[w]);
        end
        if (first || (mode ? (sum > emin) : (sum < emin))) begin
          emin = sum; ecnt = 1; eperm = pk;
        end else if (sum == emin && ecnt < cmax) begin
          ecnt++;
        end
        first = 1'b0;
      end
    end
  endtask

  task automatic run(input int dut, input bit mode, input int md, input bit inj, output int cycles);
    @(posedge CLK); #1;
    active = dut; maxd = md; acc_q.delete();
    MODE = mode; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0; MODE = ~mode; cycles = 0;
    chk("start_busy", sel_busy, 1);
    chk("start_valid", sel_valid, 0);
    while (!sel_valid && cycles < LIMIT) begin
      @(posedge CLK); #1;
      cycles++;
      if (inj && (cycles == 5)) begin
        start = 1'b1; MODE = mode;
      end else begin
        start = 1'b0; MODE = ~mode;
      end
    end
    start = 1'b0;
    chk("done_in_time", cycles < LIMIT, 1);
  endtask

  task automatic check_model(input int dut, input bit mode);
    int emin, ecnt, eperm, mism;
    model(dut, mode, (dut == 3) ? 3 : 65535, emin, ecnt, eperm);
    chk("model_min", sel_min, emin);
    chk("model_cnt", sel_cnt, ecnt);
    chk("model_perm", sel_perm, eperm);
    chk("done_valid", sel_valid, 1);
    chk("done_busy", sel_busy, 0);
    mism = 0;
    for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++) begin
      if (acc_q[i] != exp_q[i]) mism++;
    end
    chk("req_count", acc_q.size(), exp_q.size());
    chk("req_seq_mism", mism, 0);
    chk("wj_stable_err", stab_err, 0);
    chk("wj_range_err", range_err, 0);
  endtask

  task automatic chk_reset();
    chk("rst_req", sel_req, 0);
    chk("rst_busy", sel_busy, 0);
    chk("rst_valid", sel_valid, 0);
    chk("rst_w", sel_w, 0);
    chk("rst_j", sel_j, 0);
    chk("rst_min", sel_min, 0);
    chk("rst_cnt", sel_cnt, 0);
    chk("rst_perm", sel_perm, 0);
  endtask

  typedef struct {
    int dut; int pat; bit mode; int maxd; bit inject;
    int emin; int ecnt; int j0; int j1; int j2; int j3; int lat;
  } vec_t;

  vec_t vt[9];

  initial begin
    int cyc, dut, md;
    bit mode, inj;

    vt[0] = '{4, 0, 1'b0, 0, 1'b0, 4, 24, 0, 1, 2, 3, 120};
    vt[1] = '{4, 5, 1'b0, 0, 1'b0, 0, 1, 0, 1, 2, 3, 120};
    vt[2] = '{3, 1, 1'b0, 0, 1'b0, 1, 1, 2, 1, 0, 0, 24};
    vt[3] = '{3, 1, 1'b1, 0, 1'b0, 5, 1, 0, 1, 2, 0, 24};
    vt[4] = '{3, 1, 1'b0, 3, 1'b1, 1, 1, 2, 1, 0, 0, 0};
    vt[5] = '{3, 1, 1'b1, 3, 1'b1, 5, 1, 0, 1, 2, 0, 0};
    vt[6] = '{3, 4, 1'b0, 0, 1'b0, 15, 3, 0, 1, 2, 0, 24};
    vt[7] = '{2, 2, 1'b0, 0, 1'b0, 2, 1, 1, 0, 0, 0, 6};
    vt[8] = '{2, 2, 1'b1, 0, 1'b0, 6, 1, 0, 1, 0, 0, 6};

    set_pat(0, 127);
    #2 RST_N = 1'b0;
    #1;
    chk_reset();
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;

    for (int i = 0; i < 9; i++) begin
      set_pat(vt[i].pat, 127);
      run(vt[i].dut, vt[i].mode, vt[i].maxd, vt[i].inject, cyc);
      chk("tbl_min", sel_min, vt[i].emin);
      chk("tbl_cnt", sel_cnt, vt[i].ecnt);
      chk("tbl_perm", sel_perm, pack(vt[i].dut, vt[i].j0, vt[i].j1, vt[i].j2, vt[i].j3));
      if (vt[i].lat > 0) chk("tbl_latency", cyc, vt[i].lat);
      check_model(vt[i].dut, vt[i].mode);
    end

    // Reset in the middle of an N_JOBS=4 search, then a clean rerun.
    set_pat(3, 127);
    @(posedge CLK); #1;
    active = 4; maxd = 1; MODE = 1'b0; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (60) @(posedge CLK);
    #1;
    chk("mid_busy", sel_busy, 1);
    RST_N = 1'b0;
    #1;
    chk_reset();
    @(posedge CLK); #1;
    chk("rst_hold_busy", sel_busy, 0);
    chk("rst_hold_cnt", sel_cnt, 0);
    RST_N = 1'b1;
    run(4, 1'b0, 1, 1'b0, cyc);
    check_model(4, 1'b0);

    for (int it = 0; it < 8; it++) begin
      dut = 2 + $urandom_range(2, 0);
      set_pat(3, ($urandom_range(1, 0) == 1) ? 3 : 127);
      mode = 1'($urandom);
      md = $urandom_range(3, 0);
      inj = 1'($urandom);
      run(dut, mode, md, inj, cyc);
      check_model(dut, mode);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
